// File: rtl/combo_lock_pkg.sv
// Shared types for the parameterised combination lock: state encoding and display glyphs.
package combo_lock_pkg;

   typedef enum logic [1:0] {
      LOCKED   = 2'd0,
      UNLOCKED = 2'd1,
      PROGRAM  = 2'd2,
      LOCKOUT  = 2'd3
   } lockState_t;

   // Active-low seven-segment glyphs, segment order {g,f,e,d,c,b,a}
   localparam logic [6:0] GLYPH_LOCKED   = 7'b1000111;
   localparam logic [6:0] GLYPH_UNLOCKED = 7'b1000001;
   localparam logic [6:0] GLYPH_PROGRAM  = 7'b0001100;
   localparam logic [6:0] GLYPH_LOCKOUT  = 7'b0111111;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; done_o marks the final counted cycle so the owner can leave on that edge.
module lock_timer #(
   parameter int WIDTH = 11
) (
   input  logic             clkOut,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] loadVal_i,
   output logic             done_o
);

   logic [WIDTH-1:0] count_q;

   // Load wins over counting; the counter parks at zero once expired
   always_ff @(posedge clkOut or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= loadVal_i;
      end else if (count_q != '0) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign done_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/param_combo_lock.sv
// Parameterised combination lock with reprogrammable code.
// Define LOCKOUT_EN to add the wrong-digit counter and timed LOCKOUT state.
module param_combo_lock
   import combo_lock_pkg::*;
#(
   parameter int NUM_BTNS       = 4,
   parameter int CODE_LEN       = 5,
   parameter logic [CODE_LEN*$clog2(NUM_BTNS)-1:0] DEFAULT_CODE = 10'h0C3,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 1000,
   parameter int UNLOCK_CYCLES  = 2000
) (
   input  logic                          clkOut,
   input  logic                          rst,
   input  logic [NUM_BTNS-1:0]           btn_pulse,
   input  logic                          prog_en,
   output logic                          unlocked,
   output logic                          locked_out,
   output logic [$clog2(CODE_LEN+1)-1:0] progress,
   output logic [6:0]                    svnsgmnt
);

   localparam int IW   = $clog2(NUM_BTNS);
   localparam int PW   = $clog2(CODE_LEN+1);
   localparam int CW   = CODE_LEN*IW;
   localparam int TMAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
   localparam int TW   = $clog2(TMAX+1);
   localparam logic [PW-1:0] LAST_DIGIT = PW'(CODE_LEN-1);

   lockState_t    state_q, state_d;
   logic [PW-1:0] progress_q, progress_d;
   logic [CW-1:0] code_q, code_d;
   logic [CW-1:0] shadow_q, shadow_d;
   logic          timerLoad, timerDone;
   logic [TW-1:0] timerVal;
   logic          pressAny, pressValid;
   logic [IW-1:0] pressIdx, expDigit, firstDigit;

`ifdef LOCKOUT_EN
   localparam int FW = $clog2(MAX_FAILS+1);
   logic [FW-1:0] fail_q, fail_d;
`endif

   assign pressAny   = |btn_pulse;
   assign pressValid = $onehot(btn_pulse);
   assign expDigit   = code_q[int'(progress_q)*IW +: IW];
   assign firstDigit = code_q[IW-1:0];

   always_comb begin
      pressIdx = '0;
      for (int i = 0; i < NUM_BTNS; i++) begin
         if (btn_pulse[i]) pressIdx = IW'(i);
      end
   end

   lock_timer #(.WIDTH(TW)) uTimer (
      .clkOut    (clkOut),
      .rst       (rst),
      .load_i    (timerLoad),
      .loadVal_i (timerVal),
      .done_o    (timerDone)
   );

   always_ff @(posedge clkOut or posedge rst) begin
      if (rst) begin
         state_q    <= LOCKED;
         progress_q <= '0;
         code_q     <= DEFAULT_CODE;
         shadow_q   <= DEFAULT_CODE;
`ifdef LOCKOUT_EN
         fail_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         progress_q <= progress_d;
         code_q     <= code_d;
         shadow_q   <= shadow_d;
`ifdef LOCKOUT_EN
         fail_q     <= fail_d;
`endif
      end
   end

   // The live code only changes on the final PROGRAM digit, so an abort leaves it intact
   always_comb begin
      state_d    = state_q;
      progress_d = progress_q;
      code_d     = code_q;
      shadow_d   = shadow_q;
      timerLoad  = 1'b0;
      timerVal   = '0;
`ifdef LOCKOUT_EN
      fail_d     = fail_q;
`endif
      case (state_q)
         LOCKED: begin
            if (pressAny) begin
               if (pressValid && pressIdx == expDigit) begin
                  if (progress_q == LAST_DIGIT) begin
                     state_d    = UNLOCKED;
                     progress_d = '0;
                     timerLoad  = 1'b1;
                     timerVal   = TW'(UNLOCK_CYCLES);
`ifdef LOCKOUT_EN
                     fail_d     = '0;
`endif
                  end else begin
                     progress_d = progress_q + 1'b1;
                  end
               end else begin
                  progress_d = (pressValid && pressIdx == firstDigit) ? PW'(1) : '0;
`ifdef LOCKOUT_EN
                  fail_d = fail_q + 1'b1;
                  if (fail_q == FW'(MAX_FAILS-1)) begin
                     state_d    = LOCKOUT;
                     progress_d = '0;
                     timerLoad  = 1'b1;
                     timerVal   = TW'(LOCKOUT_CYCLES);
                  end
`endif
               end
            end
         end
         UNLOCKED: begin
            if (prog_en) begin
               state_d    = PROGRAM;
               progress_d = '0;
               shadow_d   = code_q;
            end else if (pressAny || timerDone) begin
               state_d = LOCKED;
            end
         end
         PROGRAM: begin
            if (!prog_en) begin
               state_d    = LOCKED;
               progress_d = '0;
            end else if (pressValid) begin
               shadow_d[int'(progress_q)*IW +: IW] = pressIdx;
               if (progress_q == LAST_DIGIT) begin
                  code_d     = shadow_d;
                  state_d    = LOCKED;
                  progress_d = '0;
               end else begin
                  progress_d = progress_q + 1'b1;
               end
            end
         end
`ifdef LOCKOUT_EN
         LOCKOUT: begin
            if (timerDone) begin
               state_d    = LOCKED;
               progress_d = '0;
               fail_d     = '0;
            end
         end
`endif
         default: begin
            state_d    = LOCKED;
            progress_d = '0;
         end
      endcase
   end

   always_comb begin
      case (state_q)
         UNLOCKED: svnsgmnt = GLYPH_UNLOCKED;
         PROGRAM:  svnsgmnt = GLYPH_PROGRAM;
         LOCKOUT:  svnsgmnt = GLYPH_LOCKOUT;
         default:  svnsgmnt = GLYPH_LOCKED;
      endcase
   end

   assign unlocked = (state_q == UNLOCKED) || (state_q == PROGRAM);
   assign progress = progress_q;
`ifdef LOCKOUT_EN
   assign locked_out = (state_q == LOCKOUT);
`else
   assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_param_combo_lock.sv
// Self-checking bench for param_combo_lock against a behavioural model of the lock rules.
module tb_param_combo_lock;

   localparam int NB    = 4;
   localparam int CL    = 5;
   localparam int PW    = 3;
   localparam int MAXF  = 3;
   localparam int LOCKC = 1000;
   localparam int UNLC  = 2000;
   localparam logic [9:0] TB_CODE = 10'h0C3;

   localparam int M_LOCKED   = 0;
   localparam int M_UNLOCKED = 1;
   localparam int M_PROGRAM  = 2;
   localparam int M_LOCKOUT  = 3;

   logic          clkOut = 1'b0;
   logic          rst = 1'b0;
   logic          prog_en = 1'b0;
   logic [NB-1:0] btn_pulse = '0;
   logic          unlocked, locked_out;
   logic [PW-1:0] progress;
   logic [6:0]    svnsgmnt;
   wire  [11:0]   obs = {unlocked, locked_out, progress, svnsgmnt};

   int checks = 0;
   int failures = 0;
   int mMode, mProg, mFails, mLeft;
   int mCode[CL];
   int mShadow[CL];

   param_combo_lock #(
      .NUM_BTNS(NB), .CODE_LEN(CL), .DEFAULT_CODE(TB_CODE),
      .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LOCKC), .UNLOCK_CYCLES(UNLC)
   ) dut (
      .clkOut     (clkOut),
      .rst        (rst),
      .btn_pulse  (btn_pulse),
      .prog_en    (prog_en),
      .unlocked   (unlocked),
      .locked_out (locked_out),
      .progress   (progress),
      .svnsgmnt   (svnsgmnt)
   );

   always #5 clkOut = ~clkOut;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [11:0] expVec();
      logic [6:0] g;
      case (mMode)
         M_UNLOCKED: g = 7'b1000001;
         M_PROGRAM:  g = 7'b0001100;
         M_LOCKOUT:  g = 7'b0111111;
         default:    g = 7'b1000111;
      endcase
      return {(mMode == M_UNLOCKED || mMode == M_PROGRAM), (mMode == M_LOCKOUT), PW'(mProg), g};
   endfunction

   task automatic modelReset();
      logic [9:0] dc;
      dc = TB_CODE;
      mMode = M_LOCKED; mProg = 0; mFails = 0; mLeft = 0;
      for (int i = 0; i < CL; i++) mCode[i] = int'(dc[2*i +: 2]);
   endtask

   task automatic modelStep(input logic [NB-1:0] btn, input logic prog);
      int nb, idx;
      nb = $countones(btn);
      idx = -1;
      for (int i = 0; i < NB; i++) if (btn[i]) idx = i;
      if (nb != 1) idx = -1;
      case (mMode)
         M_LOCKED: if (nb > 0) begin
            if (idx == mCode[mProg]) begin
               mProg++;
               if (mProg == CL) begin mMode = M_UNLOCKED; mProg = 0; mFails = 0; mLeft = UNLC; end
            end else begin
               mProg = (idx == mCode[0]) ? 1 : 0;
`ifdef LOCKOUT_EN
               mFails++;
               if (mFails >= MAXF) begin mMode = M_LOCKOUT; mLeft = LOCKC; mProg = 0; end
`endif
            end
         end
         M_UNLOCKED: begin
            if (prog) begin mMode = M_PROGRAM; mProg = 0; mShadow = mCode; end
            else if (nb > 0) mMode = M_LOCKED;
            else begin mLeft--; if (mLeft == 0) mMode = M_LOCKED; end
         end
         M_PROGRAM: begin
            if (!prog) begin mMode = M_LOCKED; mProg = 0; end
            else if (idx >= 0) begin
               mShadow[mProg] = idx;
               mProg++;
               if (mProg == CL) begin mCode = mShadow; mMode = M_LOCKED; mProg = 0; end
            end
         end
         M_LOCKOUT: begin
            mLeft--;
            if (mLeft == 0) begin mMode = M_LOCKED; mFails = 0; end
         end
         default: ;
      endcase
   endtask

   task automatic drive(input logic [NB-1:0] btn, input logic prog);
      btn_pulse = btn;
      prog_en   = prog;
      @(posedge clkOut);
      modelStep(btn, prog);
      #1;
      btn_pulse = '0;
   endtask

   task automatic doReset();
      rst = 1'b1; btn_pulse = '0; prog_en = 1'b0;
      modelReset();
      @(negedge clkOut);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; btn_pulse = '0; prog_en = 1'b0;
      modelReset();
      #12;
      checks++;
      if (obs !== 12'b0_0_000_1000111) begin
         failures++; $display("[TB] FAIL reset obs=%b exp=%b", obs, 12'b0_0_000_1000111);
      end
      @(negedge clkOut);
      rst = 1'b0;
   endtask

   task automatic test_unlock();
      int seq[5] = '{3, 0, 0, 3, 0};
      int expP[5] = '{1, 2, 3, 4, 0};
      for (int i = 0; i < 5; i++) begin
         drive(NB'(1 << seq[i]), 1'b0);
         checks++;
         if (progress !== PW'(expP[i]) || obs !== expVec()) begin
            failures++; $display("[TB] FAIL unlock_step%0d obs=%h exp=%h", i, obs, expVec());
         end
      end
      checks++;
      if (unlocked !== 1'b1 || svnsgmnt !== 7'b1000001) begin
         failures++; $display("[TB] FAIL unlock_state unlocked=%b seg=%b exp 1/1000001", unlocked, svnsgmnt);
      end
      drive(4'b0100, 1'b0);
      checks++;
      if (obs !== expVec() || unlocked !== 1'b0) begin
         failures++; $display("[TB] FAIL relock_on_press obs=%h exp=%h", obs, expVec());
      end
   endtask

   task automatic test_wrong_digit();
      int seq[7] = '{3, 0, 3, 0, 0, 3, 0};
      int expP[7] = '{1, 2, 1, 2, 3, 4, 0};
      for (int i = 0; i < 7; i++) begin
         drive(NB'(1 << seq[i]), 1'b0);
         checks++;
         if (progress !== PW'(expP[i]) || obs !== expVec()) begin
            failures++; $display("[TB] FAIL wrong_digit_step%0d obs=%h exp=%h", i, obs, expVec());
         end
      end
      checks++;
      if (unlocked !== 1'b1) begin
         failures++; $display("[TB] FAIL wrong_digit_unlock unlocked=%b exp=1", unlocked);
      end
      drive(4'b0001, 1'b0);
   endtask

   task automatic test_invalid();
      drive(4'b1000, 1'b0);
      drive(4'b0001, 1'b0);
      drive(4'b0011, 1'b0);
      checks++;
      if (progress !== 3'd0 || obs !== expVec()) begin
         failures++; $display("[TB] FAIL invalid_press progress=%0d exp=0 obs=%h model=%h", progress, obs, expVec());
      end
      drive(4'b1000, 1'b0);
      drive(4'b1111, 1'b0);
      checks++;
      if (progress !== 3'd0 || obs !== expVec()) begin
         failures++; $display("[TB] FAIL invalid_press_p1 progress=%0d exp=0", progress);
      end
      drive(4'b0000, 1'b0);
      checks++;
      if (obs !== expVec()) begin
         failures++; $display("[TB] FAIL idle_hold obs=%h exp=%h", obs, expVec());
      end
   endtask

   task automatic test_timeout();
      int seq[5] = '{3, 0, 0, 3, 0};
      for (int i = 0; i < 5; i++) drive(NB'(1 << seq[i]), 1'b0);
      for (int c = 1; c <= UNLC; c++) begin
         drive('0, 1'b0);
         checks++;
         if (obs !== expVec() || unlocked !== (c < UNLC)) begin
            failures++; $display("[TB] FAIL timeout_c%0d unlocked=%b exp=%b", c, unlocked, (c < UNLC));
         end
      end
   endtask

   task automatic test_lockout();
      doReset();
      for (int i = 0; i < 3; i++) begin
         drive(4'b0010, 1'b0);
         checks++;
         if (obs !== expVec()) begin
            failures++; $display("[TB] FAIL lockout_press%0d obs=%h exp=%h", i, obs, expVec());
         end
      end
      for (int c = 1; c <= LOCKC; c++) begin
         drive(NB'($urandom_range(0, 15)), 1'b0);
         checks++;
`ifdef LOCKOUT_EN
         if (obs !== expVec() || locked_out !== (c < LOCKC) || progress !== 3'd0) begin
            failures++; $display("[TB] FAIL lockout_c%0d locked_out=%b exp=%b progress=%0d", c, locked_out, (c < LOCKC), progress);
         end
`else
         if (obs !== expVec() || locked_out !== 1'b0) begin
            failures++; $display("[TB] FAIL no_lockout_c%0d obs=%h exp=%h", c, obs, expVec());
         end
`endif
      end
   endtask

   task automatic test_program();
      int oldC[5] = '{3, 0, 0, 3, 0};
      int newC[5] = '{1, 1, 2, 2, 1};
      doReset();
      for (int i = 0; i < 5; i++) drive(NB'(1 << oldC[i]), 1'b0);
      drive('0, 1'b1);
      checks++;
      if (svnsgmnt !== 7'b0001100 || unlocked !== 1'b1 || obs !== expVec()) begin
         failures++; $display("[TB] FAIL enter_program seg=%b exp=0001100", svnsgmnt);
      end
      for (int i = 0; i < 5; i++) begin
         drive(NB'(1 << newC[i]), 1'b1);
         checks++;
         if (obs !== expVec()) begin
            failures++; $display("[TB] FAIL program_digit%0d obs=%h exp=%h", i, obs, expVec());
         end
      end
      checks++;
      if (unlocked !== 1'b0 || svnsgmnt !== 7'b1000111) begin
         failures++; $display("[TB] FAIL program_done unlocked=%b seg=%b", unlocked, svnsgmnt);
      end
      drive('0, 1'b0);
      for (int i = 0; i < 5; i++) drive(NB'(1 << oldC[i]), 1'b0);
      checks++;
      if (unlocked !== 1'b0 || obs !== expVec()) begin
         failures++; $display("[TB] FAIL old_code_rejected unlocked=%b obs=%h exp=%h", unlocked, obs, expVec());
      end
      for (int c = 0; c < 1200 && mMode != M_LOCKED; c++) drive('0, 1'b0);
      for (int i = 0; i < 5; i++) drive(NB'(1 << newC[i]), 1'b0);
      checks++;
      if (unlocked !== 1'b1 || obs !== expVec()) begin
         failures++; $display("[TB] FAIL new_code_unlocks unlocked=%b exp=1", unlocked);
      end
      drive(4'b0001, 1'b0);
   endtask

   task automatic test_abort();
      int newC[5] = '{1, 1, 2, 2, 1};
      drive('0, 1'b1);
      checks++;
      if (unlocked !== 1'b0) begin
         failures++; $display("[TB] FAIL prog_ignored_locked unlocked=%b exp=0", unlocked);
      end
      for (int i = 0; i < 5; i++) drive(NB'(1 << newC[i]), 1'b0);
      drive(4'b1000, 1'b1);
      drive(4'b1000, 1'b1);
      drive(4'b1000, 1'b1);
      drive(4'b0100, 1'b0);
      checks++;
      if (unlocked !== 1'b0 || progress !== 3'd0 || obs !== expVec()) begin
         failures++; $display("[TB] FAIL abort obs=%h exp=%h", obs, expVec());
      end
      for (int i = 0; i < 5; i++) drive(NB'(1 << newC[i]), 1'b0);
      checks++;
      if (unlocked !== 1'b1) begin
         failures++; $display("[TB] FAIL abort_keeps_code unlocked=%b exp=1", unlocked);
      end
      drive(4'b0001, 1'b0);
   endtask

   task automatic test_reset_mid_program();
      int oldC[5] = '{3, 0, 0, 3, 0};
      int newC[5] = '{1, 1, 2, 2, 1};
      for (int i = 0; i < 5; i++) drive(NB'(1 << newC[i]), 1'b0);
      drive('0, 1'b1);
      drive(4'b0100, 1'b1);
      drive(4'b0001, 1'b1);
      rst = 1'b1;
      modelReset();
      #2;
      checks++;
      if (obs !== 12'b0_0_000_1000111) begin
         failures++; $display("[TB] FAIL reset_mid_program obs=%b exp=%b", obs, 12'b0_0_000_1000111);
      end
      prog_en = 1'b0;
      @(negedge clkOut);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) drive(NB'(1 << oldC[i]), 1'b0);
      checks++;
      if (unlocked !== 1'b1 || obs !== expVec()) begin
         failures++; $display("[TB] FAIL default_code_restored unlocked=%b exp=1", unlocked);
      end
      drive(4'b0010, 1'b0);
   endtask

   task automatic test_random();
      logic          prog;
      logic [NB-1:0] btn;
      int            r;
      prog = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 9) == 0) prog = ~prog;
         r = $urandom_range(0, 9);
         if (r < 4) btn = '0;
         else if (r < 8) btn = (mMode == M_LOCKED) ? NB'(1 << mCode[mProg]) : NB'(1 << $urandom_range(0, NB-1));
         else btn = NB'($urandom_range(0, 15));
         drive(btn, prog);
         checks++;
         if (obs !== expVec()) begin
            failures++; $display("[TB] FAIL random_c%0d btn=%b prog=%b obs=%h exp=%h", c, btn, prog, obs, expVec());
         end
      end
   endtask

   initial begin
      modelReset();
      test_reset();
      test_unlock();
      test_wrong_digit();
      test_invalid();
      test_timeout();
      test_lockout();
      test_program();
      test_abort();
      test_reset_mid_program();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
